// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the AES-192 key schedule.
package aes_pkg;

    localparam int AES192_NR = 12;
    localparam int AES192_NK = 6;
    localparam int WORD_W    = 32;
    localparam int STATE_W   = AES192_NK * WORD_W;
    localparam int RK_W      = 4 * WORD_W;

    typedef enum logic [1:0] {PH0, PH1, PH2} phase_e;

    function automatic logic [31:0] rcon_word(input logic [3:0] k);
        logic [7:0] rc;
        case (k)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Field inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes192_inv_key_step.sv
// One backward step of the AES-192 key expansion: S_k -> S_(k-1).
module aes_sbox (
    input  logic [3:0] hi,
    input  logic [3:0] lo,
    output logic [7:0] q
);
    import aes_pkg::*;

    assign q = sbox_fwd({hi, lo});

endmodule

module aes192_inv_key_step (
    input  logic [191:0] state_in,
    input  logic [31:0]  rcon,
    output logic [191:0] state_out
);
    import aes_pkg::*;

    logic [31:0] n0, n1, n2, n3, n4, n5;
    logic [31:0] p0, p1, p2, p3, p4, p5;
    logic [31:0] rot, sub;

    assign {n0, n1, n2, n3, n4, n5} = state_in;

    assign p5 = n5 ^ n4;
    assign p4 = n4 ^ n3;
    assign p3 = n3 ^ n2;
    assign p2 = n2 ^ n1;
    assign p1 = n1 ^ n0;

    assign rot = {p5[23:0], p5[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .hi (rot[8*b+7 -: 4]),
            .lo (rot[8*b+3 -: 4]),
            .q  (sub[8*b+7 -: 8])
        );
    end

    assign p0 = n0 ^ sub ^ rcon;

    assign state_out = {p0, p1, p2, p3, p4, p5};

endmodule

// File: rtl/aes192_inv_key_sched.sv
// Iterative AES-192 inverse key schedule streaming rk12 down to rk0.
module aes192_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [191:0] last_key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last
);
    import aes_pkg::*;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e       state_q;
    phase_e       phase_q;
    logic [191:0] cur_q, prev_q;
    logic [3:0]   k_q, round_q;
    logic         valid_q, ready_q, last_q;

    logic [191:0] step_in, step_out;
    logic [31:0]  step_rc;
    logic [3:0]   k_dec;
    logic         load;

    assign load    = (state_q == IDLE) && load_valid;
    assign k_dec   = k_q - 4'd1;
    assign step_in = load ? last_key : prev_q;
    assign step_rc = load ? rcon_word(4'd8) : rcon_word(k_dec);

    aes192_inv_key_step u_step (
        .state_in  (step_in),
        .rcon      (step_rc),
        .state_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH0;
            cur_q   <= '0;
            prev_q  <= '0;
            k_q     <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        state_q <= EMIT;
                        phase_q <= PH0;
                        cur_q   <= last_key;
                        prev_q  <= step_out;
                        k_q     <= 4'd8;
                        round_q <= 4'(AES192_NR);
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (round_q == 4'd0) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            last_q  <= 1'b0;
                        end else begin
                            round_q <= round_q - 4'd1;
                            last_q  <= (round_q == 4'd1);
                            unique case (phase_q)
                                PH0: phase_q <= PH1;
                                PH1, PH2: begin
                                    phase_q <= (phase_q == PH1) ? PH2 : PH0;
                                    cur_q   <= prev_q;
                                    k_q     <= k_dec;
                                    // S0 is the oldest state; nothing left to derive
                                    if (k_dec != 4'd0) prev_q <= step_out;
                                end
                                default: phase_q <= PH0;
                            endcase
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rk_data = '0;
        if (valid_q) begin
            unique case (phase_q)
                PH0:     rk_data = cur_q[191:64];
                PH1:     rk_data = prev_q[127:0];
                PH2:     rk_data = {prev_q[63:0], cur_q[191:128]};
                default: rk_data = '0;
            endcase
        end
    end

    assign load_ready = ready_q;
    assign rk_valid   = valid_q;
    assign rk_round   = round_q;
    assign rk_last    = last_q;

endmodule

// File: tb/tb_aes192_inv_key_sched.sv
// Bench for the AES-192 inverse key schedule against a forward-expansion model.
module tb_aes192_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [191:0] last_key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    int tests  = 0;
    int failed = 0;

    logic [7:0]  sbox [256];
    logic [31:0] w [54];

    localparam logic [191:0] FIPS_KEY =
        192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    localparam logic [127:0] FIPS_RK12 =
        128'he98ba06f_448c773c_8ecc7204_01002202;

    always #5 clk = ~clk;

    aes192_inv_key_sched dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .last_key   (last_key),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
        .rk_last    (rk_last)
    );

    task automatic check(input string name, input logic [134:0] act,
                         input logic [134:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        while (b != 0) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 283;
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        int inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(x, y) == 1) inv = y;
            s = inv ^ 'h63;
            for (int i = 1; i <= 4; i++)
                s = s ^ (((inv << i) | (inv >> (8 - i))) & 255);
            sbox[x] = s[7:0];
        end
    endtask

    task automatic expand(input logic [191:0] key);
        logic [31:0] t;
        int rc;
        rc = 1;
        for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
        for (int i = 6; i < 54; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc[7:0], 24'h0};
                rc = gmul(rc, 2);
            end
            w[i] = w[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_exp(input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic resync();
        rst = 1'b1;
        rk_ready = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts and ends on a negedge; consecutive calls load back-to-back.
    task automatic run_stream(input logic [191:0] key, input int stall_pct,
                              input bit inject, input int stop_after,
                              output logic [127:0] first_rk,
                              output logic [127:0] last_rk);
        int r, cyc, hs, f0;
        bit ok, rdy;
        first_rk = 'x;
        last_rk  = 'x;
        expand(key);
        cyc = 0;
        while (!load_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("load_ready", {134'd0, load_ready}, {134'd0, 1'b1});
        load_valid = 1'b1;
        last_key   = {w[48], w[49], w[50], w[51], w[52], w[53]};
        @(negedge clk);
        load_valid = 1'b0;
        r = 12; cyc = 0; hs = 0; ok = 1'b1;
        while (r >= 0 && ok) begin
            if (stop_after >= 0 && hs == stop_after) begin
                rst = 1'b1;
                rk_ready = 1'b0;
                load_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid",
                      {rk_valid, load_ready, rk_last, rk_round, rk_data},
                      {1'b0, 1'b1, 1'b0, 4'd0, 128'd0});
                return;
            end
            f0 = failed;
            check($sformatf("beat_r%0d", r),
                  {rk_valid, load_ready, rk_last, rk_round, rk_data},
                  {1'b1, 1'b0, (r == 0), r[3:0], rk_exp(r)});
            if (failed != f0) ok = 1'b0;
            if (r == 12) first_rk = rk_data;
            if (r == 0)  last_rk  = rk_data;
            rdy = ($urandom_range(99) >= stall_pct);
            rk_ready = rdy;
            if (inject) begin
                load_valid = $urandom_range(1) == 1;
                last_key = {$urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (rdy) begin
                r--;
                hs++;
            end
            cyc++;
            if (cyc > 2000) begin
                check("stream_timeout", {134'd0, 1'b1}, {134'd0, 1'b0});
                ok = 1'b0;
            end
        end
        rk_ready = 1'b0;
        load_valid = 1'b0;
        if (ok)
            check("idle_after",
                  {132'd0, rk_valid, load_ready, rk_last},
                  {132'd0, 1'b0, 1'b1, 1'b0});
        else
            resync();
    endtask

    typedef struct {
        logic [191:0] key;
        int           stall;
        bit           inject;
        bit           has12;
        logic [127:0] lit12;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [127:0] f_rk, l_rk;
        logic [191:0] key;

        vt[0] = '{FIPS_KEY, 0, 1'b0, 1'b1, FIPS_RK12};
        vt[1] = '{FIPS_KEY, 40, 1'b0, 1'b1, FIPS_RK12};
        vt[2] = '{FIPS_KEY, 25, 1'b1, 1'b1, FIPS_RK12};
        vt[3] = '{192'd0, 30, 1'b0, 1'b0, 128'd0};
        vt[4] = '{{6{32'hffffffff}}, 10, 1'b1, 1'b0, 128'd0};

        rst = 1'b1;
        load_valid = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        build_sbox();
        @(negedge clk);
        @(negedge clk);
        check("reset_state",
              {rk_valid, load_ready, rk_last, rk_round, rk_data},
              {1'b0, 1'b1, 1'b0, 4'd0, 128'd0});
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_stream(vt[i].key, vt[i].stall, vt[i].inject, -1, f_rk, l_rk);
            if (vt[i].has12)
                check($sformatf("vec%0d_rk12", i), {7'd0, f_rk}, {7'd0, vt[i].lit12});
            check($sformatf("vec%0d_rk0", i), {7'd0, l_rk}, {7'd0, vt[i].key[191:64]});
        end

        for (int n = 0; n < 100; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_stream(key, $urandom_range(50), $urandom_range(1) == 1, -1, f_rk, l_rk);
        end

        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_stream(key, 0, 1'b0, 5, f_rk, l_rk);
        run_stream(FIPS_KEY, 0, 1'b0, -1, f_rk, l_rk);
        check("restart_rk12", {7'd0, f_rk}, {7'd0, FIPS_RK12});

        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_stream(key, 0, 1'b0, -1, f_rk, l_rk);
        run_stream(FIPS_KEY, 0, 1'b0, -1, f_rk, l_rk);
        check("b2b_rk12", {7'd0, f_rk}, {7'd0, FIPS_RK12});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
